// File: rtl/i2c_irq_ctrl_pkg.sv
// Shared definitions for the I2C interrupt controller: sizes, FSM state
// encoding, named interrupt source indices and the default enable mask.
package i2c_irq_pkg;

    localparam int unsigned NUM_SRC     = 13;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned TMR_W       = 8;
    localparam int unsigned HOLDOFF_CYC = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ASSERT  = 2'd2,
        HOLDOFF = 2'd3
    } irq_state_e;

    // Bit positions of the interrupt sources in the status/event vector
    localparam int unsigned RX_FULL  = 0;
    localparam int unsigned ARB_LOST = 2;
    localparam int unsigned NACK     = 3;
    localparam int unsigned TX_EMPTY = 5;
    localparam int unsigned BUS_ERR  = 6;

    localparam logic [NUM_SRC-1:0] IRQ_EN_DEFAULT = 13'h006D;

endpackage

// File: rtl/i2c_irq_ctrl_if.sv
// Register-block side of the interrupt controller.
// master: drives events, enable mask, W1C strobe/data and coalescing config;
//         reads pending and interrupt.
// slave : the controller itself.
interface i2c_irq_ctrl_if #(
    parameter int unsigned NUM_SRC = i2c_irq_pkg::NUM_SRC,
    parameter int unsigned CNT_W   = i2c_irq_pkg::CNT_W,
    parameter int unsigned TMR_W   = i2c_irq_pkg::TMR_W
);
    logic [NUM_SRC-1:0] event_i;
    logic [NUM_SRC-1:0] irq_en;
    logic               clr_wr;
    logic [NUM_SRC-1:0] clr_mask;
    logic [CNT_W-1:0]   coal_thresh;
    logic [TMR_W-1:0]   coal_timeout;
    logic [NUM_SRC-1:0] pending;
    logic               interrupt;

    modport master (
        output event_i, irq_en, clr_wr, clr_mask, coal_thresh, coal_timeout,
        input  pending, interrupt
    );

    modport slave (
        input  event_i, irq_en, clr_wr, clr_mask, coal_thresh, coal_timeout,
        output pending, interrupt
    );
endinterface

// File: rtl/i2c_irq_ctrl_coalesce_cnt.sv
// Coalescing counter pair: saturating enabled-event counter and COLLECT timer.
// Ports: clk, rst (sync, active-high), clr (zero both counters), inc (one new
// enabled event this cycle), run (timer advances), coal_thresh, coal_timeout,
// thresh_hit_c / timeout_hit_c (combinational compares on the next-cycle view).
module irq_coalesce_cnt #(
    parameter int unsigned CNT_W = i2c_irq_pkg::CNT_W,
    parameter int unsigned TMR_W = i2c_irq_pkg::TMR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             run,
    input  logic [CNT_W-1:0] coal_thresh,
    input  logic [TMR_W-1:0] coal_timeout,
    output logic             thresh_hit_c,
    output logic             timeout_hit_c
);
    logic [CNT_W-1:0] ev_cnt;
    logic [CNT_W-1:0] ev_cnt_nxt_c;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt_c;

    // Event count including this cycle's event, saturating at all-ones
    always_comb begin
        ev_cnt_nxt_c = ev_cnt;
        if (inc && (ev_cnt != {CNT_W{1'b1}})) begin
            ev_cnt_nxt_c = ev_cnt + CNT_W'(1);
        end
    end

    // Timer only advances while staying in COLLECT; it starts from zero on entry
    always_comb begin
        timer_nxt_c = '0;
        if (!clr && run) begin
            timer_nxt_c = (timer == {TMR_W{1'b1}}) ? timer : timer + TMR_W'(1);
        end
    end

    // A zero threshold is always met since the count is unsigned
    assign thresh_hit_c  = (ev_cnt_nxt_c >= coal_thresh);
    assign timeout_hit_c = (coal_timeout != '0) && (timer == (coal_timeout - TMR_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_cnt <= '0;
            timer  <= '0;
        end else begin
            ev_cnt <= clr ? '0 : ev_cnt_nxt_c;
            timer  <= timer_nxt_c;
        end
    end
endmodule

// File: rtl/i2c_irq_ctrl.sv
// Interrupt controller for the APB I2C peripheral.
// Latches event pulses into sticky pending bits (W1C from the register block),
// masks them with irq_en and drives a single coalesced interrupt with a
// minimum low time after each deassert.
// Ports: clk, rst (sync, active-high), bus (slave modport: event_i, irq_en,
// clr_wr, clr_mask, coal_thresh, coal_timeout in; pending, interrupt out).
module i2c_irq_ctrl #(
    parameter int unsigned NUM_SRC     = i2c_irq_pkg::NUM_SRC,
    parameter int unsigned CNT_W       = i2c_irq_pkg::CNT_W,
    parameter int unsigned TMR_W       = i2c_irq_pkg::TMR_W,
    parameter int unsigned HOLDOFF_CYC = i2c_irq_pkg::HOLDOFF_CYC
) (
    input  logic           clk,
    input  logic           rst,
    i2c_irq_ctrl_if.slave  bus
);
    import i2c_irq_pkg::*;

    localparam int unsigned HC_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLDOFF_CYC - 1);

    irq_state_e         state;
    irq_state_e         state_nxt_c;
    logic [HC_W-1:0]    hcnt;
    logic [HC_W-1:0]    hcnt_nxt_c;
    logic [NUM_SRC-1:0] pending_nxt_c;
    logic               active_nxt_c;
    logic               new_ev_c;
    logic               thresh_hit_c;
    logic               timeout_hit_c;

    // Sticky pending: a new event wins over a same-cycle W1C
    always_comb begin
        pending_nxt_c = (bus.pending & ~(bus.clr_mask & {NUM_SRC{bus.clr_wr}})) | bus.event_i;
        active_nxt_c  = |(pending_nxt_c & bus.irq_en);
        new_ev_c      = |(bus.event_i & bus.irq_en);
    end

    irq_coalesce_cnt #(
        .CNT_W (CNT_W),
        .TMR_W (TMR_W)
    ) u_coalesce (
        .clk           (clk),
        .rst           (rst),
        .clr           (state_nxt_c != COLLECT),
        .inc           (new_ev_c),
        .run           (state == COLLECT),
        .coal_thresh   (bus.coal_thresh),
        .coal_timeout  (bus.coal_timeout),
        .thresh_hit_c  (thresh_hit_c),
        .timeout_hit_c (timeout_hit_c)
    );

    // Next-state logic for the coalescing FSM
    always_comb begin
        state_nxt_c = state;
        hcnt_nxt_c  = hcnt;
        unique case (state)
            IDLE: begin
                if (active_nxt_c) begin
                    state_nxt_c = thresh_hit_c ? ASSERT : COLLECT;
                end
            end
            COLLECT: begin
                if (!active_nxt_c) begin
                    state_nxt_c = IDLE;
                end else if (thresh_hit_c || timeout_hit_c) begin
                    state_nxt_c = ASSERT;
                end
            end
            ASSERT: begin
                if (!active_nxt_c) begin
                    state_nxt_c = HOLDOFF;
                    hcnt_nxt_c  = '0;
                end
            end
            HOLDOFF: begin
                // Holdoff expiry goes straight back to ASSERT without re-coalescing
                if (hcnt == HC_LAST) begin
                    state_nxt_c = active_nxt_c ? ASSERT : IDLE;
                end else begin
                    hcnt_nxt_c = hcnt + HC_W'(1);
                end
            end
            default: state_nxt_c = IDLE;
        endcase
    end

    // State, pending and interrupt registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            hcnt          <= '0;
            bus.pending   <= '0;
            bus.interrupt <= 1'b0;
        end else begin
            state         <= state_nxt_c;
            hcnt          <= hcnt_nxt_c;
            bus.pending   <= pending_nxt_c;
            bus.interrupt <= (state_nxt_c == ASSERT);
        end
    end
endmodule
